// File: rtl/mux.sv
// 4:1 single-bit multiplexer with a registered copy of the result, the
// registered select, a change pulse and a wrapping change counter.
module mux #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             S0,
    input  logic             S1,
    input  logic             EN,
    output logic             OUT,
    output logic             OUT_Q,
    output logic [1:0]       SEL_Q,
    output logic             CHG,
    output logic [CNT_W-1:0] CHG_CNT
);

    localparam int unsigned SEL_W = 2;

    logic             mux_c;
    logic             out_q_d, out_q_q;
    logic [SEL_W-1:0] sel_q_d, sel_q_q;
    logic             chg_d,   chg_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;

    // Combinational select; unknown selects fall to the default and give X.
    always_comb begin
        mux_c = 1'bx;
        case ({S1, S0})
            2'b00:   mux_c = A;
            2'b01:   mux_c = B;
            2'b10:   mux_c = C;
            2'b11:   mux_c = D;
            default: mux_c = 1'bx;
        endcase
    end

    // Next-state: capture on EN, pulse on a value change, count pulses.
    always_comb begin
        out_q_d = out_q_q;
        sel_q_d = sel_q_q;
        chg_d   = 1'b0;
        cnt_d   = cnt_q;
        if (EN) begin
            out_q_d = mux_c;
            sel_q_d = {S1, S0};
            chg_d   = (mux_c != out_q_q);
        end
        if (chg_d) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset wins over EN and drops any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_q <= 1'b0;
            sel_q_q <= '0;
            chg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            out_q_q <= out_q_d;
            sel_q_q <= sel_q_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign OUT     = mux_c;
    assign OUT_Q   = out_q_q;
    assign SEL_Q   = sel_q_q;
    assign CHG     = chg_q;
    assign CHG_CNT = cnt_q;

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for mux: stimulus pushes expectations, a monitor checks them.
module tb_mux;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic       S0 = 1'b0, S1 = 1'b0, EN = 1'b0;

    logic       out_a, out_q_a, chg_a;
    logic [1:0] sel_q_a;
    logic [7:0] cnt_a;
    logic       out_b, out_q_b, chg_b;
    logic [1:0] sel_q_b;
    logic [1:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      name;
        int         sig;
        logic [7:0] exp;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;

    mux #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .S0(S0), .S1(S1),
        .EN(EN), .OUT(out_a), .OUT_Q(out_q_a), .SEL_Q(sel_q_a), .CHG(chg_a),
        .CHG_CNT(cnt_a)
    );

    mux #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .S0(S0), .S1(S1),
        .EN(EN), .OUT(out_b), .OUT_Q(out_q_b), .SEL_Q(sel_q_b), .CHG(chg_b),
        .CHG_CNT(cnt_b)
    );

    // Clock only runs once released, so the combinational phase sees no edges.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] observe(input int sig);
        case (sig)
            0:       return {7'b0, out_a};
            1:       return {7'b0, out_q_a};
            2:       return {6'b0, sel_q_a};
            3:       return {7'b0, chg_a};
            4:       return cnt_a;
            5:       return {6'b0, cnt_b};
            6:       return {7'b0, out_q_b};
            default: return 8'hxx;
        endcase
    endfunction

    // Monitor: drains every queued expectation when stimulus flags a sample point.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = observe(e.sig);
                n_cmp++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: actual=%b required=%b at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_v(input string name, input int sig, input logic [7:0] v);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic sample();
        -> chk_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] s);
        {S1, S0} = s;
    endtask

    // Full registered-state expectation for the 8-bit counter instance.
    task automatic expect_regs(input string tag, input logic oq, input logic [1:0] sq,
                               input logic ch, input logic [7:0] cnt);
        expect_v({tag, "_out_q"}, 1, {7'b0, oq});
        expect_v({tag, "_sel_q"}, 2, {6'b0, sq});
        expect_v({tag, "_chg"},   3, {7'b0, ch});
        expect_v({tag, "_cnt"},   4, cnt);
    endtask

    initial begin
        logic [3:0] dat;
        logic [1:0] sidx;
        logic       exp_bit;
        logic [1:0] wrap_seq [5];
        logic [1:0] toggle_sel [5];

        // Combinational select with no clock edges, 100 ns holds.
        A = 1'b0; B = 1'b1; C = 1'b0; D = 1'b1;
        set_sel(2'b00); #100; expect_v("comb_sel00", 0, 8'd0); sample();
        set_sel(2'b10); #100; expect_v("comb_sel10", 0, 8'd0); sample();
        set_sel(2'b01); #100; expect_v("comb_sel01", 0, 8'd1); sample();
        set_sel(2'b11); #100; expect_v("comb_sel11", 0, 8'd1); sample();

        // Exhaustive sweep of data and select.
        for (int i = 0; i < 64; i++) begin
            dat  = 4'(i);
            sidx = 2'(i >> 4);
            {D, C, B, A} = dat;
            set_sel(sidx);
            exp_bit = dat[sidx];
            #1;
            expect_v($sformatf("sweep_%0d", i), 0, {7'b0, exp_bit});
            sample();
        end

        // Unknown select propagates X when the candidates differ.
        A = 1'b0; B = 1'b1; S1 = 1'b0; S0 = 1'bx;
        #1; expect_v("sel_x", 0, {7'b0, 1'bx}); sample();

        // Reset with EN high clears everything.
        A = 1'b0; B = 1'b1; C = 1'b0; D = 1'b1;
        set_sel(2'b11);
        clk_run = 1'b1;
        rst = 1'b1; EN = 1'b1;
        tick();
        tick();
        expect_regs("reset", 1'b0, 2'b00, 1'b0, 8'd0);
        expect_v("reset_cnt2", 5, 8'd0);
        expect_v("reset_out_live", 0, 8'd1);
        sample();
        rst = 1'b0; EN = 1'b0;
        tick();

        // First capture after reset compares against OUT_Q=0.
        EN = 1'b1; set_sel(2'b11);
        tick(); expect_regs("cap11", 1'b1, 2'b11, 1'b1, 8'd1); sample();
        set_sel(2'b01);
        tick(); expect_regs("cap01", 1'b1, 2'b01, 1'b0, 8'd1); sample();
        set_sel(2'b10);
        tick(); expect_regs("cap10", 1'b0, 2'b10, 1'b1, 8'd2); sample();

        // EN low: select toggles, registered state holds.
        EN = 1'b0;
        toggle_sel = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b11};
        for (int i = 0; i < 5; i++) begin
            set_sel(toggle_sel[i]);
            tick();
            expect_regs($sformatf("hold%0d", i), 1'b0, 2'b10, 1'b0, 8'd2);
            sample();
        end

        // Bring count to 3, then reset with a change pending.
        EN = 1'b1; set_sel(2'b01);
        tick(); expect_regs("cap_to3", 1'b1, 2'b01, 1'b1, 8'd3);
        expect_v("cnt2_is3", 5, 8'd3); sample();
        rst = 1'b1; set_sel(2'b00);
        tick(); expect_regs("midrst", 1'b0, 2'b00, 1'b0, 8'd0);
        expect_v("midrst_cnt2", 5, 8'd0);
        expect_v("midrst_out", 0, 8'd0); sample();
        A = 1'b1; #1;
        expect_v("rst_out_follows", 0, 8'd1); sample();
        rst = 1'b0; A = 1'b0;

        // Five OUT_Q toggles: 2-bit counter wraps, 8-bit keeps counting.
        wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++) begin
            set_sel((i % 2 == 0) ? 2'b01 : 2'b00);
            tick();
            expect_v($sformatf("wrap%0d_out_q2", i), 6, {7'b0, (i % 2 == 0) ? 1'b1 : 1'b0});
            expect_v($sformatf("wrap%0d_cnt2", i), 5, {6'b0, wrap_seq[i]});
            expect_v($sformatf("wrap%0d_cnt8", i), 4, 8'(i + 1));
            expect_v($sformatf("wrap%0d_chg", i), 3, 8'd1);
            sample();
        end

        // Same value captured again: pulse lasts exactly one cycle.
        tick();
        expect_regs("nochg", 1'b1, 2'b01, 1'b0, 8'd5);
        expect_v("nochg_cnt2", 5, 8'd1);
        sample();

        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: actual=%0d left required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter CNT_W, default 8, width of the change counter CHG_CNT.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 A  input  1  data input 0, selected by S1S0=00.
REQ-005 B  input  1  data input 1, selected by S1S0=01.
REQ-006 C  input  1  data input 2, selected by S1S0=10.
REQ-007 D  input  1  data input 3, selected by S1S0=11.
REQ-008 S0  input  1  select LSB.
REQ-009 S1  input  1  select MSB.
REQ-010 EN  input  1  capture enable for registered outputs.
REQ-011 OUT  output  1  combinational mux result.
REQ-012 OUT_Q  output  1  registered copy of OUT.
REQ-013 SEL_Q  output  2  registered select {S1,S0}.
REQ-014 CHG  output  1  one-cycle pulse when OUT_Q changes value.
REQ-015 CHG_CNT  output  CNT_W  count of OUT_Q value changes.

Function
REQ-016 OUT SHALL be purely combinational, with no clock dependency: {S1,S0}=00->A, 01->B, 10->C, 11->D.
REQ-017 OUT SHALL settle within the same delta as any input change, independent of clk, rst, and EN.
REQ-018 On a rising clk edge with rst=0 and EN=1, OUT_Q SHALL load OUT and SEL_Q SHALL load {S1,S0}, giving one-cycle latency.
REQ-019 With EN=0, OUT_Q and SEL_Q SHALL hold their values.
REQ-020 CHG SHALL be 1 for exactly the one cycle following an edge where EN=1 and the newly loaded OUT_Q differs from the previous OUT_Q; otherwise CHG SHALL be 0.
REQ-021 CHG_CNT SHALL increment by 1 on every edge that asserts CHG.
REQ-022 CHG_CNT SHALL wrap from 2^CNT_W-1 to 0 with no saturation or flag.
REQ-023 Select inputs that are X or Z SHALL drive OUT to X in simulation; no latches are permitted.

Reset
REQ-024 While rst=1 at a rising edge: OUT_Q=0, SEL_Q=00, CHG=0, CHG_CNT=0, regardless of EN.
REQ-025 rst SHALL NOT affect OUT; OUT continues to follow inputs during reset.
REQ-026 The first EN=1 capture after reset SHALL compare against OUT_Q=0 for CHG generation.
REQ-027 Asserting rst mid-operation SHALL discard any pending CHG pulse on that edge.

Verification
REQ-028 A=0, B=1, C=0, D=1, step {S1,S0} through 00, 10, 01, 11 with 100 ns holds, and no clock edges -> OUT = 0, 0, 1, 1 respectively.
REQ-029 With EN=1 and the same data, select 01 then 10 on consecutive edges -> OUT_Q = 1 then 0 one cycle after each edge; CHG pulses once on the 1->0 change; CHG_CNT increments by 1.
REQ-030 EN=0 while the select toggles for 5 cycles -> OUT_Q, SEL_Q, and CHG_CNT unchanged; CHG=0.
REQ-031 rst=1 for one edge after CHG_CNT=3 -> all registered outputs zero next cycle; OUT still equals the selected input.
REQ-032 CNT_W=2, force 5 OUT_Q toggles -> CHG_CNT sequence 1, 2, 3, 0, 1.
REQ-033 Exhaustive sweep of all 64 combinations of A, B, C, D, S0, S1 -> OUT always matches REQ-016.
